// File: rtl/halfwave_pwm_if.sv
// Bus between the halfwave magnitude source and the H-bridge PWM stage.
// The master drives the run control and magnitudes; the slave returns gate drives and status.
interface halfwave_pwm_if #(
    parameter int N = 9
);
    logic         enable;
    logic [N-1:0] pos_in;
    logic [N-1:0] neg_in;
    logic         period_tick;
    logic         pwm_p;
    logic         pwm_n;
    logic         fault;

    modport master (
        output enable, pos_in, neg_in,
        input  period_tick, pwm_p, pwm_n, fault
    );

    modport slave (
        input  enable, pos_in, neg_in,
        output period_tick, pwm_p, pwm_n, fault
    );
endinterface

// File: rtl/halfwave_pwm.sv
// Split-halfwave to H-bridge PWM converter: one leg per direction, dead-time on reversal,
// period strobe for the sine table, sticky fault when both halfwaves are nonzero at a sample.
module halfwave_pwm #(
    parameter int N    = 9,
    parameter int DEAD = 4
) (
    input  logic clk,
    input  logic reset,
    halfwave_pwm_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_LAST = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] GAP      = N'(DEAD);

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] gap_q, gap_d;
    logic         fault_q, fault_d;
    logic         tick_q, tick_d;
    logic         pwm_p_q, pwm_p_d;
    logic         pwm_n_q, pwm_n_d;
    logic         in_window;
    logic         pos_nz, neg_nz;

    assign pos_nz = (bus.pos_in != '0);
    assign neg_nz = (bus.neg_in != '0);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        duty_d  = duty_q;
        gap_d   = gap_q;
        fault_d = fault_q;
        if (!bus.enable) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            duty_d  = '0;
            gap_d   = '0;
            fault_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (pos_nz && !neg_nz) begin
                state_d = ST_POS;
                duty_d  = bus.pos_in;
            end else if (neg_nz && !pos_nz) begin
                state_d = ST_NEG;
                duty_d  = bus.neg_in;
            end else begin
                state_d = ST_IDLE;
                duty_d  = '0;
                if (pos_nz && neg_nz) begin
                    fault_d = 1'b1;
                end
            end
            // The outgoing period's state is the direction history, so an IDLE period forgets it.
            if ((state_d == ST_POS && state_q == ST_NEG) ||
                (state_d == ST_NEG && state_q == ST_POS)) begin
                gap_d = GAP;
            end else begin
                gap_d = '0;
            end
        end else begin
            cnt_d = cnt_q + N'(1);
        end

        // Outputs are computed from next-state values so the registered drives line up with cnt_q.
        in_window = (cnt_d >= gap_d) && (cnt_d < duty_d);
        pwm_p_d   = (state_d == ST_POS) && in_window;
        pwm_n_d   = (state_d == ST_NEG) && in_window;
        tick_d    = bus.enable && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            duty_q  <= '0;
            gap_q   <= '0;
            fault_q <= 1'b0;
            tick_q  <= 1'b0;
            pwm_p_q <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            duty_q  <= duty_d;
            gap_q   <= gap_d;
            fault_q <= fault_d;
            tick_q  <= tick_d;
            pwm_p_q <= pwm_p_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign bus.period_tick = tick_q;
    assign bus.pwm_p       = pwm_p_q;
    assign bus.pwm_n       = pwm_n_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_halfwave_pwm.sv
// Directed bench for halfwave_pwm: each period's expected gate pattern is queued when its
// magnitudes are driven and compared cycle by cycle when that period plays out.
module tb_halfwave_pwm;
    localparam int N    = 9;
    localparam int DEAD = 4;
    localparam int PER  = 511;

    typedef struct {
        int dir;   // 0 idle, 1 pos, 2 neg
        int lo;
        int hi;
        int flt;
    } exp_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic clk_run = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   overlap = 0;
    int   p_run   = 0;
    exp_t sbq[$];

    halfwave_pwm_if #(.N(N)) bus ();

    halfwave_pwm #(.N(N), .DEAD(DEAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    always @(negedge clk) begin
        if (bus.pwm_p && bus.pwm_n) overlap++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int outs_now();
        return int'({bus.pwm_p, bus.pwm_n, bus.period_tick, bus.fault});
    endfunction

    // Steps edges until period_tick is seen; reports edges taken and gate-high cycles on the way.
    task automatic wait_tick(input string tag);
        int edges;
        int highs;
        edges = 0;
        highs = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (bus.pwm_p || bus.pwm_n) highs++;
        end while (!bus.period_tick && edges < 600);
        chk({tag, "_edges"}, edges, PER - 1);
        chk({tag, "_idle_highs"}, highs, 0);
    endtask

    // Called with cnt at its last value: the next edge samples pos/neg, then a full period is checked.
    task automatic run_period(input string tag, input int pos, input int neg,
                              input int dir, input int lo, input int hi, input int flt,
                              input int glitch_k);
        exp_t e;
        int   bad_p, bad_n, bad_t, flt_obs;
        logic exp_p, exp_n;
        bus.pos_in = N'(pos);
        bus.neg_in = N'(neg);
        sbq.push_back('{dir, lo, hi, flt});
        bad_p   = 0;
        bad_n   = 0;
        bad_t   = 0;
        flt_obs = -1;
        e = sbq.pop_front();
        for (int k = 0; k < PER; k++) begin
            @(posedge clk); #1;
            exp_p = (e.dir == 1) && (k >= e.lo) && (k < e.hi);
            exp_n = (e.dir == 2) && (k >= e.lo) && (k < e.hi);
            if (bus.pwm_p !== exp_p) bad_p++;
            if (bus.pwm_n !== exp_n) bad_n++;
            if (bus.period_tick !== (k == PER - 1)) bad_t++;
            p_run = bus.pwm_p ? p_run + 1 : 0;
            if (k == PER - 1) flt_obs = int'(bus.fault);
            if (k == glitch_k) begin
                bus.pos_in = 9'd300;
                bus.neg_in = 9'd7;
            end
        end
        chk({tag, "_p_bad_cycles"}, bad_p, 0);
        chk({tag, "_n_bad_cycles"}, bad_n, 0);
        chk({tag, "_tick_bad_cycles"}, bad_t, 0);
        chk({tag, "_fault"}, flt_obs, e.flt);
        $display("period %s pos=%0d neg=%0d dir=%0d window=[%0d,%0d) fault=%0d", tag, pos, neg,
                 e.dir, e.lo, e.hi, flt_obs);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.pos_in = '0;
        bus.neg_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs_now(), 0);

        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.pos_in = 9'd100;
        wait_tick("first_tick");

        run_period("pos100_a", 100, 0, 1, 0, 100, 0, -1);
        run_period("pos100_b", 100, 0, 1, 0, 100, 0, -1);

        // Async reset mid-pulse with the clock frozen
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_pwm_p", int'(bus.pwm_p), 1);
        clk_run = 1'b0;
        #3;
        reset = 1'b0;
        #2;
        chk("async_reset_outs", outs_now(), 0);
        $display("async reset outs=%0d", outs_now());
        #20;
        clk_run = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        wait_tick("after_reset_tick");

        // Direction sequences and dead-time
        run_period("pos200", 200, 0, 1, 0, 200, 0, -1);
        run_period("neg50_rev", 0, 50, 2, DEAD, 50, 0, -1);
        run_period("neg3_same", 0, 3, 2, 0, 3, 0, -1);
        run_period("idle_a", 0, 0, 0, 0, 0, 0, -1);
        run_period("pos200_b", 200, 0, 1, 0, 200, 0, -1);
        run_period("neg3_rev_nopulse", 0, 3, 2, DEAD, 3, 0, -1);
        run_period("idle_b", 0, 0, 0, 0, 0, 0, -1);
        run_period("pos511_1", 511, 0, 1, 0, 511, 0, -1);
        run_period("pos511_2", 511, 0, 1, 0, 511, 0, -1);
        run_period("pos511_3", 511, 0, 1, 0, 511, 0, -1);
        chk("pos511_continuous_run", p_run, 3 * PER);
        run_period("neg511_rev", 0, 511, 2, DEAD, 511, 0, -1);
        run_period("pos511_rev", 511, 0, 1, DEAD, 511, 0, -1);

        // Input changes between sample points are ignored
        run_period("pos100_glitch", 100, 0, 1, 0, 100, 0, 50);

        // Sticky fault
        run_period("both_nonzero", 10, 20, 0, 0, 0, 1, -1);
        run_period("pos100_fault_held", 100, 0, 1, 0, 100, 1, -1);

        // Enable falling mid-pulse clears everything including fault
        bus.pos_in = 9'd100;
        bus.neg_in = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_disable_pwm_p", int'(bus.pwm_p), 1);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        chk("disable_outs", outs_now(), 0);
        $display("enable low outs=%0d", outs_now());
        bus.enable = 1'b1;
        wait_tick("reenable_tick");
        run_period("pos100_after_enable", 100, 0, 1, 0, 100, 0, -1);

        chk("leg_overlap_cycles", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
